// File: rtl/inst_encoder.sv
// Encodes load/store/branch field sets into 32-bit instruction words,
// range-checks the immediate, and buffers results in a 2-entry FIFO.
module inst_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    FMT_I   = 2'd0,
    FMT_S   = 2'd1,
    FMT_B   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  fmt_e               fmt;
  logic signed [31:0] imm_s;
  logic               imm12_bad;
  logic               imm13_bad;
  logic [31:0]        enc_instr;
  logic               enc_err;

  assign fmt   = fmt_e'(in_fmt);
  assign imm_s = $signed(in_imm);

  always_comb begin
    imm12_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
    imm13_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
  end

  // Errored entries carry an all-zero word so downstream never sees a partial encoding.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (fmt)
      FMT_I: begin
        enc_err   = imm12_bad;
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
      end
      FMT_S: begin
        enc_err   = imm12_bad;
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
      end
      FMT_B: begin
        enc_err   = imm13_bad;
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      default: begin
        enc_err   = 1'b1;
        enc_instr = '0;
      end
    endcase
    if (enc_err) enc_instr = '0;
  end

  logic [31:0] mem_instr [2];
  logic        mem_err   [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_instr[i] <= '0;
        mem_err[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_instr[tail] <= enc_instr;
        mem_err[tail]   <= enc_err;
        tail            <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_instr = out_valid ? mem_instr[head] : '0;
  assign out_err   = out_valid ? mem_err[head]   : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (push && enc_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed requests push hand-computed
// expected words; a monitor pops and compares on every FIFO handshake.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [31:0] in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_funct3(in_funct3), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drives one request and holds it until accepted (bounded).
  task automatic send(input logic [1:0] fmt, input logic [31:0] imm,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [2:0] f3,
                      input logic err, input logic [31:0] instr);
    bit done = 0;
    @(posedge clk); #1;
    in_fmt = fmt; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_funct3 = f3; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({err, instr});
        if (err && exp_err < 255) exp_err++;
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected acceptance");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got %h, expected no entry", out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  task automatic drain;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_fmt = '0; in_imm = '0; in_rs1 = '0;
    in_rs2 = '0; in_rd = '0; in_funct3 = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic encodings
    send(2'd0, -32'sd4, 5'd2, 5'd0, 5'd5, 3'd2, 1'b0, 32'hFFC12283);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    send(2'd1, 32'd8, 5'd2, 5'd5, 5'd0, 3'd2, 1'b0, 32'h00512423);
    send(2'd2, -32'sd8, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'hFE208CE3);
    drain();

    // Error cases
    send(2'd2, 32'd3, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'h0);
    send(2'd0, 32'd2048, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'h0);
    drain();
    check("err_count_2", {24'd0, err_count}, 32'd2);
    send(2'd3, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'h0);
    send(2'd0, -32'sd2049, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'h0);
    drain();

    // Reset with two entries buffered and five errors counted
    out_ready = 1'b0;
    send(2'd1, 32'd2048, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 32'h0);
    send(2'd0, 32'd2047, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 32'h7FF00083);
    check("pre_rst_err_count", {24'd0, err_count}, exp_err);
    check("pre_rst_err5", {24'd0, err_count}, 32'd5);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    check("mid_rst_out_instr", out_instr, 32'd0);
    exp_q.delete(); exp_err = 0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    send(2'd0, -32'sd2048, 5'd31, 5'd9, 5'd31, 3'd7, 1'b0, 32'h800FFF83);
    send(2'd1, -32'sd2048, 5'd0, 5'd1, 5'd31, 3'd0, 1'b0, 32'h80100023);
    check("bp_full", {31'd0, in_ready}, 32'd0);
    fork
      send(2'd1, 32'd2047, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h7E000FA3);
    join_none
    repeat (3) @(negedge clk);
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, 32'h800FFF83);
    check("bp_third_pending", exp_q.size(), 32'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Branch boundaries
    send(2'd2, 32'd4094, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h7E000FE3);
    send(2'd2, -32'sd4096, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h80000063);
    send(2'd2, 32'd4096, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 32'h0);
    send(2'd2, -32'sd4098, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 32'h0);
    drain();
    check("bound_err_count", {24'd0, err_count}, exp_err);

    // Saturation
    for (int i = 0; i < 256; i++)
      send(2'd3, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 32'h0);
    drain();
    check("sat_err_count", {24'd0, err_count}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
